de_issue_ctrl: RTL
==================

# de_issue_ctrl

Decode-stage issue controller between fetch and the decode/execute boundary. It buffers fetched instructions in a 2-entry queue and presents the head to decode. It decides each cycle whether the decoded instruction may issue, handling load-use interlock, multiply/divide busy, execute backpressure, branch-delay-slot tagging, post-exception halt and pipeline flush. It also counts decode stall cycles for performance monitoring.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: instruction queue entries. Only 2 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_inst` in 32, `if_pc` in 32: fetched word and its PC.
- `if_ready` out 1: queue can accept. Equals `count != 2`; forced 0 while `resetn` = 0.
- `de_valid` out 1, `de_inst` out 32, `de_pc` out 32: queue head driven to decode.
- `de_r_en1`, `de_r_en2` in 1; `de_r_addr1`, `de_r_addr2` in 5: decode source-register usage.
- `de_is_branch` in 1: head is a branch/jump.
- `de_is_md` in 1: head is mult/div/mfhi/mflo/mthi/mtlo.
- `de_exc` in 1: OR of decode `except_type` bits.
- `ex_valid`, `ex_is_load` in 1; `ex_w_addr` in 5: instruction currently in execute.
- `md_busy` in 1: multiply/divide unit occupied.
- `ex_ready` in 1: execute accepts this cycle.
- `flush` in 1: exception or eret redirect from commit.
- `issue` out 1: head moves to execute this cycle.
- `issue_in_ds` out 1: issued instruction is a delay slot.
- `stall_cause` out 2: 0 none, 1 load-use, 2 md busy, 3 ex backpressure or halt.
- `stall_cnt` out 32: decode stall cycles.

## Operation
- Queue:
  - push = `if_valid & if_ready & !flush`.
  - pop = `issue`.
  - Simultaneous push and pop keeps the count and advances the head.
- Hazard terms:
  - `lu` = `ex_valid & ex_is_load & ex_w_addr != 0 & ((de_r_en1 & de_r_addr1 == ex_w_addr) | (de_r_en2 & de_r_addr2 == ex_w_addr))`.
  - `mdb` = `de_is_md & md_busy`.
- Issue rule: `issue` = `de_valid & !lu & !mdb & ex_ready & state != HALT & !flush`.
- `stall_cause` priority: lu > mdb > (`!ex_ready` or HALT). Value is 0 when `!de_valid` or when issuing.
- States:
  - RUN → WAIT_DS on issue with `de_is_branch`.
  - WAIT_DS → RUN on the next issue; `issue_in_ds` = 1 for that issue. A branch in a delay slot is not re-tagged.
  - RUN or WAIT_DS → HALT on issue with `de_exc`. HALT wins over WAIT_DS.
  - HALT → RUN only on `flush`.
- `issue_in_ds` = `issue & state == WAIT_DS`.
- Flush has top priority:
  - Empties the queue and returns to RUN.
  - Drops any same-cycle push.
  - `issue` = 0 that cycle.
- `stall_cnt` increments when `de_valid & !issue & !flush`. It wraps at 2^32 and is not cleared by flush.

## Timing
- Reset values: count 0, `de_valid` 0, `de_inst`/`de_pc` 0, state RUN, `stall_cnt` 0, `issue` 0, `stall_cause` 0.
- Fetch-to-decode latency: a word pushed in cycle N is the head (`de_valid` = 1) in cycle N+1 when the queue was empty.
- `de_*` outputs come directly from head registers.
- `issue`, `issue_in_ds` and `stall_cause` are combinational on the current inputs. No registered outputs are used in the issue path.
- `if_ready` depends only on registered count, so there is no combinational path from `ex_ready` to `if_ready`. When full, no push occurs even if a pop happens in the same cycle.
- Load-use stall lasts exactly one cycle when execute advances its load.
- Reset asserted mid-operation clears everything asynchronously; in-flight entries are lost.

## Structure
- Shared constants go in `defines_cpu.vh`:
  - state encodings (RUN 2'd0, WAIT_DS 2'd1, HALT 2'd2);
  - `stall_cause` codes;
  - `FIFO_DEPTH`.
- Sub-module `de_inst_fifo`: 2-entry queue of {pc, inst} with push/pop/flush, count and head outputs.
- Hazard logic, FSM and counter live in the top level.

## Test plan
- Push pc 0xBFC00000 then 0xBFC00004 with `ex_ready` = 1 → `de_valid` in cycle 1; `issue` in cycles 1 and 2; `if_ready` is 1 throughout.
- Head `de_r_en1` = 1, `de_r_addr1` = 5; execute `ex_is_load` = 1, `ex_w_addr` = 5 → `issue` = 0 and `stall_cause` = 1 for one cycle, `stall_cnt` = 1; issue follows on the next cycle. The same stimulus with `ex_w_addr` = 0 → no stall.
- Issue a branch, then hold `if_valid` = 0 for 3 cycles, then supply pc 0x80000008 → the next issue has `issue_in_ds` = 1, and the state returns to RUN.
- Issue with `de_exc` = 1 while the queue holds 1 entry → no further issue (`stall_cause` = 3) until `flush`; flush empties the queue, and the next push issues normally.
- Queue full with `ex_ready` = 0 → `if_ready` = 0. Assert `ex_ready` and `if_valid` together → pop occurs and push is blocked that cycle; push is accepted the following cycle.
- `flush` in the same cycle as a push and an issuable head → `issue` = 0, queue empty next cycle, `if_ready` = 1.

Source files
------------

// File: rtl/de_issue_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package de_issue_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_DS = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    localparam logic [1:0] SC_NONE         = 2'd0;
    localparam logic [1:0] SC_LOAD_USE     = 2'd1;
    localparam logic [1:0] SC_MD_BUSY      = 2'd2;
    localparam logic [1:0] SC_BACKPRESSURE = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    // True when an enabled source register matches the execute destination.
    function automatic logic src_hit(input logic en, input logic [4:0] addr,
                                     input logic [4:0] waddr);
        return en & (addr == waddr);
    endfunction

endpackage

// File: rtl/de_issue_ctrl_fifo.sv
// Two-entry instruction queue; the head slot drives decode directly.
module de_issue_ctrl_fifo
    import de_issue_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  fifo_entry_t i_wr_entry,
    output logic        o_full,
    output logic        o_head_vld,
    output fifo_entry_t o_head
);

    localparam logic [1:0] LP_FULL = 2'(FIFO_DEPTH);

    logic [1:0]  r_count;
    logic        r_head_vld;
    fifo_entry_t r_head;
    fifo_entry_t r_tail;

    // Queue state: push/pop never collide with a full queue because push
    // is gated by the full flag and pop needs a valid head.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_count    <= 2'd0;
            r_head_vld <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (i_flush) begin
            r_count    <= 2'd0;
            r_head_vld <= 1'b0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head     <= i_wr_entry;
                        r_head_vld <= 1'b1;
                        r_count    <= 2'd1;
                    end else begin
                        r_tail  <= i_wr_entry;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end else begin
                        r_head_vld <= 1'b0;
                        r_count    <= 2'd0;
                    end
                end
                2'b11: begin
                    // Only reachable with one entry: replace the head in place.
                    r_head <= i_wr_entry;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_full     = (r_count == LP_FULL);
    assign o_head_vld = r_head_vld;
    assign o_head     = r_head;

endmodule

// File: rtl/de_issue_ctrl.sv
// Decode-stage issue controller: queue, hazard checks, delay-slot/halt FSM
// and stall-cycle counter.
module de_issue_ctrl
    import de_issue_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        de_valid,
    output logic [31:0] de_inst,
    output logic [31:0] de_pc,
    input  logic        de_r_en1,
    input  logic        de_r_en2,
    input  logic [4:0]  de_r_addr1,
    input  logic [4:0]  de_r_addr2,
    input  logic        de_is_branch,
    input  logic        de_is_md,
    input  logic        de_exc,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_w_addr,
    input  logic        md_busy,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        issue,
    output logic        issue_in_ds,
    output logic [1:0]  stall_cause,
    output logic [31:0] stall_cnt
);

    state_e      r_state;
    logic [31:0] r_stall_cnt;
    logic        w_full;
    logic        w_push;
    logic        w_lu;
    logic        w_mdb;
    logic        w_issue;
    logic [1:0]  w_cause;
    fifo_entry_t w_head;
    fifo_entry_t w_wr_entry;

    // if_ready only looks at registered occupancy, keeping ex_ready out of it.
    assign if_ready   = resetn & ~w_full;
    assign w_push     = if_valid & if_ready & ~flush;
    assign w_wr_entry = '{pc: if_pc, inst: if_inst};

    de_issue_ctrl_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_push     (w_push),
        .i_pop      (w_issue),
        .i_flush    (flush),
        .i_wr_entry (w_wr_entry),
        .o_full     (w_full),
        .o_head_vld (de_valid),
        .o_head     (w_head)
    );

    assign de_inst = w_head.inst;
    assign de_pc   = w_head.pc;

    // Hazard detection, issue decision and stall reason for the current head.
    always_comb begin
        w_lu    = ex_valid & ex_is_load & (ex_w_addr != 5'd0) &
                  (src_hit(de_r_en1, de_r_addr1, ex_w_addr) |
                   src_hit(de_r_en2, de_r_addr2, ex_w_addr));
        w_mdb   = de_is_md & md_busy;
        w_issue = de_valid & ~w_lu & ~w_mdb & ex_ready &
                  (r_state != ST_HALT) & ~flush;
        w_cause = SC_NONE;
        if (de_valid && !w_issue) begin
            if (w_lu)
                w_cause = SC_LOAD_USE;
            else if (w_mdb)
                w_cause = SC_MD_BUSY;
            else if (!ex_ready || r_state == ST_HALT)
                w_cause = SC_BACKPRESSURE;
        end
    end

    assign issue       = w_issue;
    assign issue_in_ds = w_issue & (r_state == ST_WAIT_DS);
    assign stall_cause = w_cause;

    // Delay-slot / halt tracking; flush always returns to RUN and an
    // excepting issue wins over delay-slot tagging.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
        end else if (flush) begin
            r_state <= ST_RUN;
        end else if (w_issue) begin
            if (de_exc)
                r_state <= ST_HALT;
            else if (r_state == ST_WAIT_DS)
                r_state <= ST_RUN;
            else if (de_is_branch)
                r_state <= ST_WAIT_DS;
        end
    end

    // Stall-cycle counter: wraps naturally and survives flushes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= 32'd0;
        else if (de_valid && !w_issue && !flush)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;

endmodule
